// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder slice.
// Defines default geometry, chunk derivation and the parameter legality check.
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

// Elaboration-time guard: WIDTH must be positive and split evenly into STAGES.
`define PA_CHECK_PARAMS(W, S) \
  if ((W) < 1 || (S) < 1 || ((W) % (S)) != 0) begin : g_param_check \
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES"); \
  end

package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

`endif

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// slave is the adder's view; master is the source/sink side.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/pipelined_adder_chunk.sv
// Combinational ripple-carry chunk built from full_adder cells; zero latency, no handshake.
// cmsb exposes the carry into the top bit so the last stage can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_chunk #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  // For a 1-bit chunk this is simply the incoming carry.
  assign cmsb = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunk stages; result appears STAGES cycles after acceptance.
// Global stall (out_valid && !out_ready) freezes every stage and drops in_ready.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  `PA_CHECK_PARAMS(WIDTH, STAGES)

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic             ovf_q [STAGES];
  logic             stall;

  assign stall        = vld_q[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = rst_n && !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] sum_prev;
    logic [WIDTH-1:0] sum_d;
    logic             cin_d;
    logic [CHUNK-1:0] s_chunk;
    logic             cout_chunk;
    logic             cmsb_chunk;

    // Operands ride along whole so chunk k meets its carry at stage k.
    if (k == 0) begin : g_first
      assign vld_d    = bus.in_valid;
      assign a_d      = bus.in_a;
      assign b_d      = bus.in_b;
      assign sum_prev = '0;
      assign cin_d    = bus.in_cin;
    end else begin : g_next
      assign vld_d    = vld_q[k-1];
      assign a_d      = a_q[k-1];
      assign b_d      = b_q[k-1];
      assign sum_prev = sum_q[k-1];
      assign cin_d    = cy_q[k-1];
    end

    adder_chunk #(
      .WIDTH (CHUNK)
    ) u_chunk (
      .a    (a_d[k*CHUNK +: CHUNK]),
      .b    (b_d[k*CHUNK +: CHUNK]),
      .cin  (cin_d),
      .sum  (s_chunk),
      .cout (cout_chunk),
      .cmsb (cmsb_chunk)
    );

    always_comb begin
      sum_d                    = sum_prev;
      sum_d[k*CHUNK +: CHUNK]  = s_chunk;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (!stall) begin
        vld_q[k] <= vld_d;
        a_q[k]   <= a_d;
        b_q[k]   <= b_d;
        sum_q[k] <= sum_d;
        cy_q[k]  <= cout_chunk;
        ovf_q[k] <= cmsb_chunk ^ cout_chunk;
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_sum   = sum_q[STAGES-1];
  assign bus.out_cout  = cy_q[STAGES-1];
  assign bus.out_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: randomized and directed traffic against an arithmetic reference model.
module tb_pipelined_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  res_t exp_q [$];

  // Shared stimulus for the 8-bit STAGES=1 and STAGES=8 instances.
  logic       sw_iv;
  logic [7:0] sw_a, sw_b;
  logic       sw_cin;
  // Stimulus for the 32-bit STAGES=4 instance.
  logic        w_iv;
  logic [31:0] w_a, w_b;
  logic        w_cin;

  pipelined_adder_if #(.WIDTH(8))  m_if  ();
  pipelined_adder_if #(.WIDTH(8))  s1_if ();
  pipelined_adder_if #(.WIDTH(8))  s8_if ();
  pipelined_adder_if #(.WIDTH(32)) w_if  ();

  pipelined_adder #(.WIDTH(8),  .STAGES(2)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_s1   (.clk(clk), .rst_n(rst_n), .bus(s1_if));
  pipelined_adder #(.WIDTH(8),  .STAGES(8)) u_s8   (.clk(clk), .rst_n(rst_n), .bus(s8_if));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_w32  (.clk(clk), .rst_n(rst_n), .bus(w_if));

  assign s1_if.in_valid  = sw_iv;
  assign s1_if.in_a      = sw_a;
  assign s1_if.in_b      = sw_b;
  assign s1_if.in_cin    = sw_cin;
  assign s1_if.out_ready = 1'b1;
  assign s8_if.in_valid  = sw_iv;
  assign s8_if.in_a      = sw_a;
  assign s8_if.in_b      = sw_b;
  assign s8_if.in_cin    = sw_cin;
  assign s8_if.out_ready = 1'b1;
  assign w_if.in_valid   = w_iv;
  assign w_if.in_a       = w_a;
  assign w_if.in_b       = w_b;
  assign w_if.in_cin     = w_cin;
  assign w_if.out_ready  = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    res_t       r;
    logic [8:0] full;
    full   = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (a[7] == b[7]) && (r.sum[7] != a[7]);
    return r;
  endfunction

  // One cycle on the main instance: drive, sample before the edge, log accepted operands.
  task automatic run_cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic ordy,
                           output logic ov, output logic [7:0] s, output logic co,
                           output logic of, output logic ir, output logic fired);
    m_if.in_valid  = iv;
    m_if.in_a      = a;
    m_if.in_b      = b;
    m_if.in_cin    = cin;
    m_if.out_ready = ordy;
    #1;
    ov    = m_if.out_valid;
    s     = m_if.out_sum;
    co    = m_if.out_cout;
    of    = m_if.out_ovf;
    ir    = m_if.in_ready;
    fired = iv && ir;
    if (fired) exp_q.push_back(ref_add8(a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_if.out_valid); end
    checks++; if (m_if.out_sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", m_if.out_sum); end
    checks++; if ({m_if.out_cout, m_if.out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", m_if.out_cout, m_if.out_ovf); end
    checks++; if (m_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", m_if.in_ready); end
    checks++; if ({s1_if.out_valid, s8_if.out_valid, w_if.out_valid} !== 3'b000) begin errors++; $display("FAIL reset_sweep_valid: got %b expected 000", {s1_if.out_valid, s8_if.out_valid, w_if.out_valid}); end
    rst_n = 1'b1;
    #1;
    checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", m_if.in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [3];
    logic [7:0] tb_ [3];
    logic [9:0] texp [3];
    logic ov, co, of, ir, f;
    logic [7:0] s;
    ta   = '{8'hFF, 8'h7F, 8'h80};
    tb_  = '{8'h01, 8'h01, 8'h80};
    texp = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      int nval;
      int vcyc;
      logic [9:0] got;
      nval = 0; vcyc = -1; got = '0;
      for (int c = 0; c < 6; c++) begin
        run_cycle(c == 0, ta[i], tb_[i], 1'b0, 1'b1, ov, s, co, of, ir, f);
        if (ov) begin nval++; vcyc = c; got = {s, co, of}; end
      end
      exp_q.delete();
      checks++; if (nval !== 1) begin errors++; $display("FAIL directed_pulse[%0d]: got %0d valid cycles expected 1", i, nval); end
      checks++; if (vcyc !== 2) begin errors++; $display("FAIL directed_latency[%0d]: got cycle %0d expected 2", i, vcyc); end
      checks++; if (got !== texp[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, got, texp[i]); end
    end
  endtask

  task automatic test_streaming();
    logic [7:0] pa, pb, s;
    logic pc, ov, co, of, ir, f;
    res_t e;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    pa = 8'($urandom); pb = 8'($urandom); pc = 1'($urandom);
    for (int c = 0; c < 24; c++) begin
      run_cycle(sent < 16, pa, pb, pc, 1'b1, ov, s, co, of, ir, f);
      if (f) begin sent++; pa = 8'($urandom); pb = 8'($urandom); pc = 1'($urandom); end
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got result %h with no operation outstanding", s);
        end else begin
          e = exp_q.pop_front();
          if ({s, co, of} !== {e.sum, e.cout, e.ovf}) begin errors++; $display("FAIL stream_result[%0d]: got %h/%b/%b expected %h/%b/%b", got, s, co, of, e.sum, e.cout, e.ovf); end
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    checks++; if (got !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", got); end
    checks++; if (last - first !== 15) begin errors++; $display("FAIL stream_contiguous: got span %0d expected 15", last - first); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic pc [3];
    logic [7:0] ca, cb, s, held;
    logic cc, ordy, ov, co, of, ir, f;
    res_t e;
    int idx, got;
    idx = 0; got = 0; held = '0;
    for (int i = 0; i < 3; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); pc[i] = 1'($urandom); end
    for (int c = 0; c < 20; c++) begin
      ordy = !(c >= 2 && c < 7);
      ca = (idx < 3) ? pa[idx] : 8'h00;
      cb = (idx < 3) ? pb[idx] : 8'h00;
      cc = (idx < 3) ? pc[idx] : 1'b0;
      run_cycle(idx < 3, ca, cb, cc, ordy, ov, s, co, of, ir, f);
      if (f) idx++;
      if (c == 2) held = s;
      if (c >= 2 && c < 7) begin
        checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b expected 0", c, ir); end
        checks++; if ({ov, s} !== {1'b1, held}) begin errors++; $display("FAIL bp_hold[c%0d]: got %b/%h expected 1/%h", c, ov, s, held); end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got result %h with no operation outstanding", s);
        end else begin
          e = exp_q.pop_front();
          if ({s, co, of} !== {e.sum, e.cout, e.ovf}) begin errors++; $display("FAIL bp_result[%0d]: got %h/%b/%b expected %h/%b/%b", got, s, co, of, e.sum, e.cout, e.ovf); end
        end
        got++;
      end
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got); end
    checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] s;
    logic ov, co, of, ir, f;
    int stale;
    stale = 0;
    run_cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, ov, s, co, of, ir, f);
    run_cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, ov, s, co, of, ir, f);
    run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ov, s, co, of, ir, f);
    rst_n = 1'b0;
    run_cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, ov, s, co, of, ir, f);
    rst_n = 1'b1;
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b expected 0", ir); end
    exp_q.delete();
    run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ov, s, co, of, ir, f);
    checks++; if ({ov, s, co, of} !== 11'b0) begin errors++; $display("FAIL midreset_outputs: got %b/%h/%b/%b expected all 0", ov, s, co, of); end
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ov, s, co, of, ir, f);
      if (ov) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL midreset_stale: got %0d stale results expected 0", stale); end
  endtask

  task automatic test_sweep_short();
    res_t e;
    for (int rep = 0; rep < 2; rep++) begin
      int n1, n8, c1, c8;
      logic [9:0] r1, r8;
      n1 = 0; n8 = 0; c1 = -1; c8 = -1; r1 = '0; r8 = '0;
      sw_a = 8'($urandom); sw_b = 8'($urandom); sw_cin = 1'($urandom);
      e = ref_add8(sw_a, sw_b, sw_cin);
      for (int c = 0; c < 12; c++) begin
        sw_iv = (c == 0);
        #1;
        if (s1_if.out_valid) begin n1++; c1 = c; r1 = {s1_if.out_sum, s1_if.out_cout, s1_if.out_ovf}; end
        if (s8_if.out_valid) begin n8++; c8 = c; r8 = {s8_if.out_sum, s8_if.out_cout, s8_if.out_ovf}; end
        @(posedge clk);
        #1;
      end
      checks++; if ({n1, c1} !== {32'd1, 32'd1}) begin errors++; $display("FAIL s1_latency[%0d]: got %0d pulses at cycle %0d expected 1 at 1", rep, n1, c1); end
      checks++; if (r1 !== {e.sum, e.cout, e.ovf}) begin errors++; $display("FAIL s1_result[%0d]: got %h expected %h", rep, r1, {e.sum, e.cout, e.ovf}); end
      checks++; if ({n8, c8} !== {32'd1, 32'd8}) begin errors++; $display("FAIL s8_latency[%0d]: got %0d pulses at cycle %0d expected 1 at 8", rep, n8, c8); end
      checks++; if (r8 !== {e.sum, e.cout, e.ovf}) begin errors++; $display("FAIL s8_result[%0d]: got %h expected %h", rep, r8, {e.sum, e.cout, e.ovf}); end
    end
  endtask

  task automatic test_sweep_wide();
    for (int rep = 0; rep < 2; rep++) begin
      int nw, cw;
      logic [33:0] got, expv;
      logic [32:0] full;
      nw = 0; cw = -1; got = '0;
      if (rep == 0) begin w_a = 32'hFFFF_FFFF; w_b = 32'h0; w_cin = 1'b1; end
      else begin w_a = $urandom; w_b = $urandom; w_cin = 1'($urandom); end
      full = {1'b0, w_a} + {1'b0, w_b} + {32'b0, w_cin};
      expv = {full[31:0], full[32], (w_a[31] == w_b[31]) && (full[31] != w_a[31])};
      for (int c = 0; c < 10; c++) begin
        w_iv = (c == 0);
        #1;
        if (w_if.out_valid) begin nw++; cw = c; got = {w_if.out_sum, w_if.out_cout, w_if.out_ovf}; end
        @(posedge clk);
        #1;
      end
      checks++; if ({nw, cw} !== {32'd1, 32'd4}) begin errors++; $display("FAIL w32_latency[%0d]: got %0d pulses at cycle %0d expected 1 at 4", rep, nw, cw); end
      checks++; if (got !== expv) begin errors++; $display("FAIL w32_result[%0d]: got %h expected %h", rep, got, expv); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_a = '0; m_if.in_b = '0; m_if.in_cin = 1'b0; m_if.out_ready = 1'b1;
    sw_iv = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
    w_iv = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0;
    test_reset();
    test_directed();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_sweep_short();
    test_sweep_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 8-bit ripple-carry adder.
- Splits a WIDTH-bit addition into STAGES equal chunks. Each pipeline stage resolves one chunk and registers the carry into the next stage.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Produces sum, carry-out and signed overflow STAGES cycles later. Sits between operand sources and any downstream datapath needing wide, timing-closed addition.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- STAGES, 2, number of pipeline stages; must divide WIDTH exactly (elaboration error otherwise). CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  sum of in_a + in_b + in_cin, modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface decided: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge) clears:
  - all stage valid bits and all data/carry registers;
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- in_ready is 0 whenever rst_n is low.
- Transfer rules:
  - Input transfer occurs on a cycle with in_valid && in_ready.
  - Output transfer occurs on a cycle with out_valid && out_ready.
- Stall (global, whole-pipe) = out_valid && !out_ready.
  - in_ready = !stall (when rst_n high).
  - On stall, every stage register holds its value.
  - No bubble compression is required; bubbles advance only when not stalled.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k of A and B, i.e. bits [k*CHUNK +: CHUNK], with the carry registered from stage k-1. Stage 0 uses in_cin.
  - Upper operand chunks are skewed (delayed) so that chunk k arrives at stage k together with its carry.
  - Completed lower sum chunks are delayed so that all chunks emerge aligned.
- Latency: result for an input accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 (visible in cycle N+STAGES), absent stalls.
- Throughput: one result per cycle while out_ready=1.
- STAGES=1: purely a registered adder, latency 1 cycle.
- Overflow:
  - out_ovf is computed in the last stage from the carry into MSB and the carry out of MSB.
  - For WIDTH=1, carry into MSB = in_cin (delayed).
- Stage valid bits propagate with data. Invalid slots must not assert out_valid, regardless of stale data.
- Simultaneous in transfer and out transfer in the same cycle is legal. Both complete and the pipe advances by one.
- out_* data is stable (held) while out_valid && !out_ready.
- Reset asserted mid-operation discards all in-flight operations. No result for them is ever produced.
- in_valid while in_ready=0: operands are ignored. The source must hold them (standard valid/ready; in_valid must not depend on in_ready).

Decomposition:
- Shared package/header:
  - default WIDTH/STAGES constants;
  - a localparam CHUNK derivation;
  - the elaboration check macro for WIDTH % STAGES.
- One sub-module: adder_chunk.
  - Combinational CHUNK-bit ripple adder instantiating full_adder per bit.
  - Ports: a, b, cin, sum, cout, plus carry-into-MSB for overflow.
  - Generated once per stage.
- The top level holds the skew/de-skew registers, valid chain and stall logic.

Test Plan:
1. WIDTH=8, STAGES=2: in_a=0xFF, in_b=0x01, in_cin=0, out_ready=1 → two cycles after acceptance, out_sum=0x00, out_cout=1, out_ovf=0, out_valid pulses for one cycle.
2. WIDTH=8, STAGES=2: 0x7F+0x01, cin=0 → out_sum=0x80, out_cout=0, out_ovf=1; then 0x80+0x80 → out_sum=0x00, out_cout=1, out_ovf=1.
3. Streaming: 16 back-to-back random pairs with out_ready=1 → 16 consecutive out_valid cycles, results in order, each matching a reference model (a+b+cin).
4. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles with 3 operations in flight.
   - Response: in_ready=0 while stalled; out_sum stable; no loss or duplication.
   - After release: remaining results drain in order.
5. Reset mid-flight: drive rst_n low for one edge with 2 operations in flight → out_valid=0 and all outputs 0 next cycle; no stale result ever appears afterwards.
6. Parameter sweep:
   - WIDTH=32, STAGES=4, 0xFFFFFFFF+0+cin=1 → out_sum=0, out_cout=1 after 4 cycles.
   - WIDTH=8, STAGES=1: latency 1 cycle.
   - WIDTH=8, STAGES=8: latency 8 cycles.
